// File: rtl/erase_draw_pkg.sv
// Shared FSM state type and background-band colour helper for erase_draw_blk.
package erase_draw_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  // Rows at or below the split belong to the white-key band.
  function automatic logic [31:0] band_color(input logic [31:0] y,
                                             input logic [31:0] split,
                                             input logic [31:0] upper,
                                             input logic [31:0] lower);
    return (y >= split) ? lower : upper;
  endfunction

endpackage

// File: rtl/erase_draw_blk_scan_ctr.sv
// blk_scan_ctr: raster dx/dy counter (dx inner, dy outer) exposing next-cycle values.
module blk_scan_ctr #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned CNT_H = 4,
  parameter int unsigned DX_W  = 8,
  parameter int unsigned DY_W  = 7
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            start,
  input  logic            advance,
  output logic [DX_W-1:0] dx_nxt,
  output logic [DY_W-1:0] dy_nxt,
  output logic            last
);

  localparam logic [DX_W-1:0] DX_MAX = DX_W'(CNT_W - 1);
  localparam logic [DY_W-1:0] DY_MAX = DY_W'(CNT_H - 1);

  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;

  always_comb begin
    dx_nxt = dx;
    dy_nxt = dy;
    if (start) begin
      dx_nxt = '0;
      dy_nxt = '0;
    end else if (advance) begin
      if (dx == DX_MAX) begin
        dx_nxt = '0;
        dy_nxt = (dy == DY_MAX) ? '0 : dy + 1'b1;
      end else begin
        dx_nxt = dx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= dx_nxt;
      dy <= dy_nxt;
    end
  end

  assign last = (dx == DX_MAX) && (dy == DY_MAX);

endmodule

// File: rtl/erase_draw_blk.sv
// Block marker plotter: erases the previous W x H block in band background, draws the new one.
// Optional power-up screen clear enabled by defining ERASE_DRAW_CLEAR_EN.
module erase_draw_blk
  import erase_draw_pkg::*;
#(
  parameter int unsigned      X_W         = 8,
  parameter int unsigned      Y_W         = 7,
  parameter int unsigned      COLOR_W     = 3,
  parameter int unsigned      BLK_W       = 4,
  parameter int unsigned      BLK_H       = 4,
  parameter int unsigned      SCREEN_W    = 160,
  parameter int unsigned      SCREEN_H    = 120,
  parameter int unsigned      KEY_Y_SPLIT = 89,
  parameter logic [COLOR_W-1:0] BG_UPPER  = 3'b000,
  parameter logic [COLOR_W-1:0] BG_LOWER  = 3'b111
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               req,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [COLOR_W-1:0] color_in,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               plot
);

  state_t state, state_nxt;

  logic [X_W-1:0]     cur_x, cur_x_nxt, prev_x, prev_x_nxt, pend_x, pend_x_nxt, job_x;
  logic [Y_W-1:0]     cur_y, cur_y_nxt, prev_y, prev_y_nxt, pend_y, pend_y_nxt, job_y;
  logic [COLOR_W-1:0] cur_c, cur_c_nxt, pend_c, pend_c_nxt, job_c;
  logic               prev_valid, prev_valid_nxt, pend_valid, pend_valid_nxt;
  logic               done_nxt, take, clr_hold;

  logic               bs_start, bs_adv, bs_last;
  logic [X_W-1:0]     bs_dx_nxt;
  logic [Y_W-1:0]     bs_dy_nxt;

  logic [X_W-1:0]     base_x, x_nxt;
  logic [Y_W-1:0]     base_y, y_nxt;
  logic [COLOR_W-1:0] color_nxt;
  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;
  logic               plot_nxt;

  blk_scan_ctr #(.CNT_W(BLK_W), .CNT_H(BLK_H), .DX_W(X_W), .DY_W(Y_W)) u_blk_ctr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (bs_start),
    .advance  (bs_adv),
    .dx_nxt   (bs_dx_nxt),
    .dy_nxt   (bs_dy_nxt),
    .last     (bs_last)
  );

`ifdef ERASE_DRAW_CLEAR_EN
  logic           clr_todo, clr_todo_nxt;
  logic           sc_start, sc_adv, sc_last;
  logic [X_W-1:0] sc_dx_nxt;
  logic [Y_W-1:0] sc_dy_nxt;

  blk_scan_ctr #(.CNT_W(SCREEN_W), .CNT_H(SCREEN_H), .DX_W(X_W), .DY_W(Y_W)) u_clr_ctr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (sc_start),
    .advance  (sc_adv),
    .dx_nxt   (sc_dx_nxt),
    .dy_nxt   (sc_dy_nxt),
    .last     (sc_last)
  );
`endif

  always_comb begin
    state_nxt      = state;
    cur_x_nxt      = cur_x;
    cur_y_nxt      = cur_y;
    cur_c_nxt      = cur_c;
    prev_x_nxt     = prev_x;
    prev_y_nxt     = prev_y;
    prev_valid_nxt = prev_valid;
    pend_x_nxt     = pend_x;
    pend_y_nxt     = pend_y;
    pend_c_nxt     = pend_c;
    pend_valid_nxt = pend_valid;
    done_nxt       = 1'b0;
    bs_start       = 1'b0;
    bs_adv         = 1'b0;
    take           = 1'b0;
    job_x          = pend_x;
    job_y          = pend_y;
    job_c          = pend_c;
    clr_hold       = 1'b0;
`ifdef ERASE_DRAW_CLEAR_EN
    clr_todo_nxt   = clr_todo;
    sc_start       = 1'b0;
    sc_adv         = 1'b0;
    clr_hold       = clr_todo;
`endif

    // A request that cannot start this cycle lands in the pending slot (latest wins).
    if (req && (state != S_IDLE || clr_hold || pend_valid)) begin
      pend_x_nxt     = x_in;
      pend_y_nxt     = y_in;
      pend_c_nxt     = color_in;
      pend_valid_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (clr_hold) begin
`ifdef ERASE_DRAW_CLEAR_EN
          state_nxt    = S_CLEAR;
          sc_start     = 1'b1;
          clr_todo_nxt = 1'b0;
`endif
        end else begin
          if (pend_valid) begin
            take           = 1'b1;
            pend_valid_nxt = req;
          end else if (req) begin
            take  = 1'b1;
            job_x = x_in;
            job_y = y_in;
            job_c = color_in;
          end
          if (take) begin
            cur_x_nxt = job_x;
            cur_y_nxt = job_y;
            cur_c_nxt = job_c;
            bs_start  = 1'b1;
            state_nxt = prev_valid ? S_ERASE : S_DRAW;
          end
        end
      end
      S_ERASE: begin
        if (bs_last) begin
          state_nxt = S_DRAW;
          bs_start  = 1'b1;
        end else begin
          bs_adv = 1'b1;
        end
      end
      S_DRAW: begin
        if (bs_last) begin
          state_nxt      = S_IDLE;
          prev_x_nxt     = cur_x;
          prev_y_nxt     = cur_y;
          prev_valid_nxt = 1'b1;
          done_nxt       = 1'b1;
        end else begin
          bs_adv = 1'b1;
        end
      end
      S_CLEAR: begin
`ifdef ERASE_DRAW_CLEAR_EN
        if (sc_last) state_nxt = S_IDLE;
        else         sc_adv    = 1'b1;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output registers load the pixel for the state being entered, so the
  // first pixel of a job is visible in the cycle right after acceptance.
  always_comb begin
    base_x    = (state_nxt == S_ERASE) ? prev_x_nxt : cur_x_nxt;
    base_y    = (state_nxt == S_ERASE) ? prev_y_nxt : cur_y_nxt;
    sum_x     = {1'b0, base_x} + {1'b0, bs_dx_nxt};
    sum_y     = {1'b0, base_y} + {1'b0, bs_dy_nxt};
    x_nxt     = x_out;
    y_nxt     = y_out;
    color_nxt = color_out;
    plot_nxt  = 1'b0;
    case (state_nxt)
      S_ERASE, S_DRAW: begin
        x_nxt     = sum_x[X_W-1:0];
        y_nxt     = sum_y[Y_W-1:0];
        color_nxt = (state_nxt == S_DRAW) ? cur_c_nxt
                  : COLOR_W'(band_color(32'(sum_y), KEY_Y_SPLIT, 32'(BG_UPPER), 32'(BG_LOWER)));
        plot_nxt  = (32'(sum_x) < SCREEN_W) && (32'(sum_y) < SCREEN_H);
      end
`ifdef ERASE_DRAW_CLEAR_EN
      S_CLEAR: begin
        x_nxt     = sc_dx_nxt;
        y_nxt     = sc_dy_nxt;
        color_nxt = COLOR_W'(band_color(32'(sc_dy_nxt), KEY_Y_SPLIT, 32'(BG_UPPER), 32'(BG_LOWER)));
        plot_nxt  = 1'b1;
      end
`endif
      default: plot_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_c      <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_c     <= '0;
      pend_valid <= 1'b0;
      done       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      color_out  <= '0;
      plot       <= 1'b0;
`ifdef ERASE_DRAW_CLEAR_EN
      clr_todo   <= 1'b1;
`endif
    end else begin
      state      <= state_nxt;
      cur_x      <= cur_x_nxt;
      cur_y      <= cur_y_nxt;
      cur_c      <= cur_c_nxt;
      prev_x     <= prev_x_nxt;
      prev_y     <= prev_y_nxt;
      prev_valid <= prev_valid_nxt;
      pend_x     <= pend_x_nxt;
      pend_y     <= pend_y_nxt;
      pend_c     <= pend_c_nxt;
      pend_valid <= pend_valid_nxt;
      done       <= done_nxt;
      x_out      <= x_nxt;
      y_out      <= y_nxt;
      color_out  <= color_nxt;
      plot       <= plot_nxt;
`ifdef ERASE_DRAW_CLEAR_EN
      clr_todo   <= clr_todo_nxt;
`endif
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_erase_draw_blk.sv
// Directed + randomized bench for erase_draw_blk (default build, 4x4 block, 160x120 screen).
module tb_erase_draw_blk;

  localparam int BW = 4;
  localparam int BH = 4;
  localparam int N  = BW * BH;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       req;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] color_in;
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] color_out;

  int checks = 0;
  int errors = 0;

  // Reference model: the last completed block.
  bit m_prev_valid;
  int m_px, m_py;

  erase_draw_blk dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .req       (req),
    .x_in      (x_in),
    .y_in      (y_in),
    .color_in  (color_in),
    .busy      (busy),
    .done      (done),
    .x_out     (x_out),
    .y_out     (y_out),
    .color_out (color_out),
    .plot      (plot)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int jx, input int jy, input int jc);
    @(negedge CLOCK_50);
    req      = 1'b1;
    x_in     = 8'(jx);
    y_in     = 7'(jy);
    color_in = 3'(jc);
  endtask

  // Checks every cycle of a job whose accept edge is the next posedge, then the done cycle.
  // With inject set, two requests are fired mid-job to exercise the pending slot.
  task automatic expect_job(input int jx, input int jy, input int jc, input bit inject);
    int total;
    total = m_prev_valid ? 2 * N : N;
    for (int k = 0; k < total; k++) begin
      bit erase;
      int idx, ex, ey, ecol;
      bit eplot;
      logic [31:0] epix;
      @(negedge CLOCK_50);
      if (k == 0) req = 1'b0;
      if (inject) begin
        case (k)
          3: begin req = 1'b1; x_in = 8'd30; y_in = 7'd30; color_in = 3'd1; end
          4: begin x_in = 8'd40; y_in = 7'd40; color_in = 3'd6; end
          5: req = 1'b0;
          default: ;
        endcase
      end
      erase = m_prev_valid && (k < N);
      idx   = k % N;
      ex    = (erase ? m_px : jx) + idx % BW;
      ey    = (erase ? m_py : jy) + idx / BW;
      eplot = (ex < 160) && (ey < 120);
      ecol  = erase ? ((ey >= 89) ? 7 : 0) : jc;
      epix  = 32'({ex[7:0], ey[6:0], ecol[2:0]});
      chk(erase ? "erase_plot" : "draw_plot", 32'(plot), 32'(eplot));
      if (eplot) chk(erase ? "erase_pixel" : "draw_pixel", 32'({x_out, y_out, color_out}), epix);
      chk("busy_active", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
    end
    @(negedge CLOCK_50);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("plot_at_done", 32'(plot), 32'd0);
    m_prev_valid = 1'b1;
    m_px = jx;
    m_py = jy;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; x_in = '0; y_in = '0; color_in = '0;
    m_prev_valid = 1'b0; m_px = 0; m_py = 0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_outputs", 32'({busy, done, plot, x_out, y_out, color_out}), 32'd0);
    reset = 1'b0;

    // First draw skips erase; then erase into lower band, straddle and clipping cases.
    issue(10, 20, 3'b100);  expect_job(10, 20, 3'b100, 1'b0);
    chk("done_one_cycle", 32'(done), 32'd1);
    issue(10, 90, 3'b010);  expect_job(10, 90, 3'b010, 1'b0);
    issue(5, 87, 3'b011);   expect_job(5, 87, 3'b011, 1'b0);
    issue(20, 30, 3'b101);  expect_job(20, 30, 3'b101, 1'b0);
    issue(158, 40, 3'b110); expect_job(158, 40, 3'b110, 1'b0);
    issue(100, 118, 3'b001); expect_job(100, 118, 3'b001, 1'b0);

    // Pending: (30,30) is overwritten by (40,40); only the latter runs.
    issue(50, 50, 3'b011);  expect_job(50, 50, 3'b011, 1'b1);
    expect_job(40, 40, 3'b110, 1'b0);
    repeat (3) begin
      @(negedge CLOCK_50);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_plot", 32'(plot), 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      int rx, ry, rc;
      rx = $urandom_range(0, 170);
      ry = $urandom_range(0, 127);
      rc = $urandom_range(0, 7);
      issue(rx, ry, rc);
      expect_job(rx, ry, rc, 1'b0);
    end

    // Reset in the middle of the draw phase.
    issue(60, 60, 3'b010);
    @(negedge CLOCK_50);
    req = 1'b0;
    repeat (N + 4) @(negedge CLOCK_50);
    chk("mid_draw_busy", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1 chk("async_rst_outputs", 32'({busy, done, plot, x_out, y_out, color_out}), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    m_prev_valid = 1'b0;
    issue(70, 10, 3'b101);  expect_job(70, 10, 3'b101, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
